// File: rtl/imm_field_encoder.sv
// Packs a 64-bit immediate into the 26-bit instruction immediate field, range-checking it
// and splitting wide MOVZ constants into a MOVZ beat followed by MOVK beats.
module imm_field_encoder #(
   parameter int NUM_CHUNKS = 4
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        InValid,
   output logic        InReady,
   input  logic [63:0] Value,
   input  logic [2:0]  Ctrl,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [25:0] Imm26,
   output logic [2:0]  OutCtrl,
   output logic        Last,
   output logic        Err
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] EMIT = 1'b1;

   localparam logic [2:0] CTRL_I    = 3'b000;
   localparam logic [2:0] CTRL_D    = 3'b001;
   localparam logic [2:0] CTRL_B    = 3'b010;
   localparam logic [2:0] CTRL_CBZ  = 3'b011;
   localparam logic [2:0] CTRL_MOVZ = 3'b100;
   localparam logic [2:0] CTRL_MOVK = 3'b101;

   logic [0:0]            state_reg;
   logic [63:0]           value_reg;
   logic [NUM_CHUNKS-1:0] mask_reg;
   logic                  out_valid_reg;
   logic [25:0]           imm_reg;
   logic [2:0]            out_ctrl_reg;
   logic                  last_reg;
   logic                  err_reg;

   logic [NUM_CHUNKS-1:0] in_mask;
   logic                  in_fire;
   logic                  out_fire;

   logic                  acc_ok;
   logic [25:0]           acc_imm;
   logic                  acc_last;
   logic [1:0]            acc_hw;
   logic [NUM_CHUNKS-1:0] acc_rest;

   logic [1:0]            emit_hw;
   logic [NUM_CHUNKS-1:0] emit_rest;
   logic [25:0]           emit_imm;

   function automatic logic [1:0] low_idx(input logic [NUM_CHUNKS-1:0] m);
      logic [1:0] idx;
      idx = 2'd0;
      for (int k = NUM_CHUNKS - 1; k >= 0; k--) begin
         if (m[k]) idx = k[1:0];
      end
      return idx;
   endfunction

   for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_mask
      assign in_mask[gi] = |Value[16*gi +: 16];
   end

   assign InReady  = (state_reg == IDLE) && (!out_valid_reg || OutReady);
   assign in_fire  = InValid && InReady;
   assign out_fire = out_valid_reg && OutReady;

   assign OutValid = out_valid_reg;
   assign Imm26    = imm_reg;
   assign OutCtrl  = out_ctrl_reg;
   assign Last     = last_reg;
   assign Err      = err_reg;

   always_comb begin
      acc_ok   = 1'b0;
      acc_imm  = 26'd0;
      acc_last = 1'b1;
      acc_hw   = low_idx(in_mask);
      acc_rest = '0;
      case (Ctrl)
         CTRL_I: begin
            acc_ok  = ~|Value[63:12];
            acc_imm = {4'b0, Value[11:0], 10'b0};
         end
         CTRL_D: begin
            acc_ok  = (&Value[63:8]) || (~|Value[63:8]);
            acc_imm = {5'b0, Value[8:0], 12'b0};
         end
         CTRL_B: begin
            acc_ok  = (Value[1:0] == 2'b00) && ((&Value[63:27]) || (~|Value[63:27]));
            acc_imm = Value[27:2];
         end
         CTRL_CBZ: begin
            acc_ok  = (Value[1:0] == 2'b00) && ((&Value[63:20]) || (~|Value[63:20]));
            acc_imm = {2'b0, Value[20:2], 5'b0};
         end
         CTRL_MOVZ: begin
            // Remaining chunks after the first beat: clear the lowest set bit.
            acc_ok   = 1'b1;
            acc_rest = in_mask & (in_mask - NUM_CHUNKS'(1));
            acc_imm  = {3'b0, acc_hw, Value[16*acc_hw +: 16], 5'b0};
            acc_last = (acc_rest == '0);
         end
         default: acc_ok = 1'b0;
      endcase
      if (!acc_ok) begin
         acc_imm  = 26'd0;
         acc_last = 1'b1;
         acc_rest = '0;
      end
   end

   always_comb begin
      emit_hw   = low_idx(mask_reg);
      emit_rest = mask_reg & (mask_reg - NUM_CHUNKS'(1));
      emit_imm  = {3'b0, emit_hw, value_reg[16*emit_hw +: 16], 5'b0};
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_reg     <= IDLE;
         value_reg     <= 64'd0;
         mask_reg      <= '0;
         out_valid_reg <= 1'b0;
         imm_reg       <= 26'd0;
         out_ctrl_reg  <= 3'b000;
         last_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else if (in_fire) begin
         value_reg     <= Value;
         mask_reg      <= acc_rest;
         out_valid_reg <= 1'b1;
         imm_reg       <= acc_imm;
         out_ctrl_reg  <= Ctrl;
         last_reg      <= acc_last;
         err_reg       <= !acc_ok;
         state_reg     <= acc_last ? IDLE : EMIT;
      end else if (out_fire) begin
         if (state_reg == EMIT && !last_reg) begin
            mask_reg     <= emit_rest;
            imm_reg      <= emit_imm;
            out_ctrl_reg <= CTRL_MOVK;
            last_reg     <= (emit_rest == '0);
            err_reg      <= 1'b0;
         end else begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Self-checking bench for imm_field_encoder: table-driven single-beat vectors plus
// hand-written MOVZ split, stall and mid-request reset sequences, checked by a scoreboard.
module tb_imm_field_encoder;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [63:0] Value;
   logic [2:0]  Ctrl;
   logic        OutValid;
   logic        OutReady;
   logic [25:0] Imm26;
   logic [2:0]  OutCtrl;
   logic        Last;
   logic        Err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [25:0] imm;
      logic [2:0]  ctrl;
      logic        last;
      logic        err;
   } beat_t;

   typedef struct {
      logic [2:0]  ctrl;
      logic [63:0] value;
      logic [25:0] imm;
      logic [2:0]  octrl;
      logic        err;
   } vec_t;

   beat_t exp_q[$];
   int    beats_seen = 0;

   imm_field_encoder #(.NUM_CHUNKS(4)) dut (
      .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .Value(Value), .Ctrl(Ctrl), .OutValid(OutValid), .OutReady(OutReady),
      .Imm26(Imm26), .OutCtrl(OutCtrl), .Last(Last), .Err(Err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Scoreboard: every consumed beat is compared against the oldest expected beat.
   always @(negedge CLK) begin
      if (!Reset && OutValid && OutReady) begin
         beats_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: actual imm=0x%0h ctrl=%0d last=%0b err=%0b required=none",
                     Imm26, OutCtrl, Last, Err);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            if (Imm26 !== e.imm || OutCtrl !== e.ctrl || Last !== e.last || Err !== e.err) begin
               errors++;
               $display("FAIL beat: actual imm=0x%0h ctrl=%0d last=%0b err=%0b required imm=0x%0h ctrl=%0d last=%0b err=%0b",
                        Imm26, OutCtrl, Last, Err, e.imm, e.ctrl, e.last, e.err);
            end else begin
               $display("beat ok: imm=0x%0h ctrl=%0d last=%0b err=%0b", Imm26, OutCtrl, Last, Err);
            end
         end
      end
   end

   function automatic void push_beat(input logic [25:0] imm, input logic [2:0] c,
                                     input logic last, input logic err);
      beat_t b;
      b.imm = imm; b.ctrl = c; b.last = last; b.err = err;
      exp_q.push_back(b);
   endfunction

   // Reference split of a MOVZ constant into beats.
   function automatic void push_movz(input logic [63:0] v);
      logic [15:0] ch [4];
      logic        first;
      logic        higher;
      for (int k = 0; k < 4; k++) ch[k] = v[16*k +: 16];
      if (v == 64'd0) begin
         push_beat(26'd0, 3'b100, 1'b1, 1'b0);
         return;
      end
      first = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (ch[k] != 16'd0) begin
            higher = 1'b0;
            for (int j = k + 1; j < 4; j++) if (ch[j] != 16'd0) higher = 1'b1;
            push_beat((26'(k) << 21) | (26'(ch[k]) << 5), first ? 3'b100 : 3'b101, !higher, 1'b0);
            first = 1'b0;
         end
      end
   endfunction

   task automatic send(input logic [2:0] c, input logic [63:0] v);
      logic accepted;
      InValid = 1'b1; Ctrl = c; Value = v;
      accepted = 1'b0;
      for (int i = 0; i < 100 && !accepted; i++) begin
         @(negedge CLK);
         if (InReady) accepted = 1'b1;
         @(posedge CLK); #1;
      end
      InValid = 1'b0;
      Ctrl = 3'($urandom);
      Value = {$urandom, $urandom};
      if (!accepted) begin
         checks++; errors++;
         $display("FAIL send_timeout: actual=not accepted required=accepted ctrl=%0d", c);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge CLK); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: actual pending=%0d required pending=0", exp_q.size());
      end
   endtask

   initial begin
      vec_t vecs[$];
      vec_t v;
      logic [25:0] snap_imm;
      logic [2:0]  snap_ctrl;
      logic        snap_last;
      logic        ok;

      vecs.push_back('{3'b000, 64'h0000_0000_0000_0FFF, 26'h03FFC00, 3'b000, 1'b0});
      vecs.push_back('{3'b000, 64'h0000_0000_0000_1000, 26'h0,       3'b000, 1'b1});
      vecs.push_back('{3'b001, 64'hFFFF_FFFF_FFFF_FF00, 26'h0100000, 3'b001, 1'b0});
      vecs.push_back('{3'b001, 64'h0000_0000_0000_0100, 26'h0,       3'b001, 1'b1});
      vecs.push_back('{3'b001, 64'h0000_0000_0000_00FF, 26'h00FF000, 3'b001, 1'b0});
      vecs.push_back('{3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 26'h3FFFFFF, 3'b010, 1'b0});
      vecs.push_back('{3'b010, 64'h0000_0000_0000_0006, 26'h0,       3'b010, 1'b1});
      vecs.push_back('{3'b010, 64'h0000_0000_0800_0000, 26'h0,       3'b010, 1'b1});
      vecs.push_back('{3'b011, 64'h0000_0000_0000_0008, 26'h0000040, 3'b011, 1'b0});
      vecs.push_back('{3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 26'h0FFFFE0, 3'b011, 1'b0});
      vecs.push_back('{3'b100, 64'h0000_0000_0000_0000, 26'h0,       3'b100, 1'b0});
      vecs.push_back('{3'b000, 64'h0000_0000_0000_0005, 26'h0001400, 3'b000, 1'b0});
      vecs.push_back('{3'b101, 64'h0000_0000_0000_0001, 26'h0,       3'b101, 1'b1});
      vecs.push_back('{3'b111, 64'h0000_0000_0000_0001, 26'h0,       3'b111, 1'b1});

      Reset = 1'b1; InValid = 1'b0; Value = 64'd0; Ctrl = 3'b000; OutReady = 1'b1;
      repeat (3) @(posedge CLK);
      #1 Reset = 1'b0;
      @(negedge CLK);
      check("reset_outvalid", 64'(OutValid), 64'd0);
      check("reset_imm",      64'(Imm26),    64'd0);
      check("reset_outctrl",  64'(OutCtrl),  64'd0);
      check("reset_last",     64'(Last),     64'd0);
      check("reset_err",      64'(Err),      64'd0);
      check("reset_inready",  64'(InReady),  64'd1);
      @(posedge CLK); #1;

      // Single-beat vectors issued back to back.
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         push_beat(v.imm, v.octrl, 1'b1, v.err);
         send(v.ctrl, v.value);
      end
      drain();

      // MOVZ split into two beats without a bubble.
      push_beat(26'h01579A0, 3'b100, 1'b0, 1'b0);
      push_beat(26'h0624680, 3'b101, 1'b1, 1'b0);
      send(3'b100, 64'h1234_0000_0000_ABCD);
      @(negedge CLK);
      check("movz_inready_between", 64'(InReady), 64'd0);
      @(negedge CLK);
      check("movz_no_bubble_valid", 64'(OutValid), 64'd1);
      check("movz_no_bubble_ctrl",  64'(OutCtrl),  64'd5);
      drain();

      // Stall mid-split: outputs must hold while OutReady is low.
      OutReady = 1'b0;
      push_movz(64'h0000_5678_0000_0001);
      send(3'b100, 64'h0000_5678_0000_0001);
      @(negedge CLK);
      snap_imm = Imm26; snap_ctrl = OutCtrl; snap_last = Last;
      check("stall_first_imm", 64'(snap_imm), 64'h20);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         ok = OutValid && (Imm26 == snap_imm) && (OutCtrl == snap_ctrl) && (Last == snap_last);
         check("stall_hold", 64'(ok), 64'd1);
      end
      @(posedge CLK); #1 OutReady = 1'b1;
      drain();
      check("stall_beat_count", 64'(beats_seen), 64'(vecs.size() + 4));

      // Reset after the second of four beats discards the rest.
      push_movz(64'hFFFF_FFFF_FFFF_FFFF);
      send(3'b100, 64'hFFFF_FFFF_FFFF_FFFF);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (exp_q.size() == 2) ok = 1'b1;
         else begin @(posedge CLK); #1; end
      end
      check("reset_wait_two_beats", 64'(ok), 64'd1);
      Reset = 1'b1;
      exp_q.delete();
      @(posedge CLK); #1 Reset = 1'b0;
      @(negedge CLK);
      check("midreset_outvalid", 64'(OutValid), 64'd0);
      check("midreset_inready",  64'(InReady),  64'd1);
      @(posedge CLK); #1;
      push_beat(26'h0001400, 3'b000, 1'b1, 1'b0);
      send(3'b000, 64'd5);
      drain();
      repeat (3) @(posedge CLK);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
